// File: rtl/anim_pkg.sv
// Shared types and widths for the player sprite animation sequencer and sprite ROM builder.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2
  } anim_state_t;

  localparam int unsigned FRAME_IDX_W  = 3;
  localparam int unsigned SPRITE_SEL_W = 5;

  localparam int unsigned DEFAULT_IDLE_LEN = 2;
  localparam int unsigned DEFAULT_WALK_LEN = 4;
  localparam int unsigned DEFAULT_JUMP_LEN = 3;

endpackage

// File: rtl/toggle_step_detect.sv
// Turns every edge of a slow level into a one-cycle step pulse.
module toggle_step_detect (
  input  logic Clk,
  input  logic level_i,
  output logic step_o
);

  logic level_q;

  // Tracks the level even in reset, so the first cycle after reset never sees a step.
  always_ff @(posedge Clk) begin
    level_q <= level_i;
  end

  assign step_o = level_i ^ level_q;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Steps the player sprite through idle/walk/jump clips on each changeFrame toggle and
// produces the sprite ROM frame select and mirror control.
module sprite_anim_sequencer
  import anim_pkg::*;
#(
  parameter int unsigned IDLE_LEN = DEFAULT_IDLE_LEN,
  parameter int unsigned WALK_LEN = DEFAULT_WALK_LEN,
  parameter int unsigned JUMP_LEN = DEFAULT_JUMP_LEN
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    changeFrame,
  input  logic                    walk,
  input  logic                    dir_left,
  input  logic                    jump_req,
  output logic [1:0]              anim_state,
  output logic [FRAME_IDX_W-1:0]  frame_idx,
  output logic [SPRITE_SEL_W-1:0] sprite_sel,
  output logic                    facing_left,
  output logic                    jump_done
);

  if (IDLE_LEN < 1 || IDLE_LEN > 8) begin : g_bad_idle_len
    $error("IDLE_LEN must be in 1..8");
  end
  if (WALK_LEN < 1 || WALK_LEN > 8) begin : g_bad_walk_len
    $error("WALK_LEN must be in 1..8");
  end
  if (JUMP_LEN < 1 || JUMP_LEN > 8) begin : g_bad_jump_len
    $error("JUMP_LEN must be in 1..8");
  end

  localparam logic [FRAME_IDX_W-1:0] IdleLast = FRAME_IDX_W'(IDLE_LEN - 1);
  localparam logic [FRAME_IDX_W-1:0] WalkLast = FRAME_IDX_W'(WALK_LEN - 1);
  localparam logic [FRAME_IDX_W-1:0] JumpLast = FRAME_IDX_W'(JUMP_LEN - 1);

  anim_state_t            state_q, state_d;
  logic [FRAME_IDX_W-1:0] idx_q, idx_d;
  logic                   facing_q, facing_d;
  logic                   done_q, done_d;
  logic                   step;

  toggle_step_detect u_step_detect (
    .Clk     (Clk),
    .level_i (changeFrame),
    .step_o  (step)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    facing_d = (walk && state_q != JUMP) ? dir_left : facing_q;

    // A state change takes priority and swallows a coincident step.
    unique case (state_q)
      IDLE: begin
        if (jump_req) begin
          state_d = JUMP;
          idx_d   = '0;
        end else if (walk) begin
          state_d = WALK;
          idx_d   = '0;
        end else if (step) begin
          idx_d = (idx_q == IdleLast) ? '0 : idx_q + 1'b1;
        end
      end
      WALK: begin
        if (jump_req) begin
          state_d = JUMP;
          idx_d   = '0;
        end else if (!walk) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (step) begin
          idx_d = (idx_q == WalkLast) ? '0 : idx_q + 1'b1;
        end
      end
      JUMP: begin
        if (step) begin
          if (idx_q == JumpLast) begin
            state_d = walk ? WALK : IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      facing_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      facing_q <= facing_d;
      done_q   <= done_d;
    end
  end

  assign anim_state  = state_q;
  assign frame_idx   = idx_q;
  assign sprite_sel  = {state_q, idx_q};
  assign facing_left = facing_q;
  assign jump_done   = done_q;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Self-checking bench: directed vector table plus random stimulus against a clip-level model,
// on a default-length instance and a short-clip instance driven in parallel.
module tb_sprite_anim_sequencer;

  logic Clk = 1'b0;
  logic Reset, changeFrame, walk, dir_left, jump_req;

  logic [1:0] st0, st1;
  logic [2:0] idx0, idx1;
  logic [4:0] sel0, sel1;
  logic       face0, face1, done0, done1;

  always #5 Clk = ~Clk;

  sprite_anim_sequencer #(.IDLE_LEN(2), .WALK_LEN(4), .JUMP_LEN(3)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .changeFrame(changeFrame), .walk(walk), .dir_left(dir_left),
    .jump_req(jump_req), .anim_state(st0), .frame_idx(idx0), .sprite_sel(sel0),
    .facing_left(face0), .jump_done(done0)
  );

  sprite_anim_sequencer #(.IDLE_LEN(1), .WALK_LEN(4), .JUMP_LEN(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .changeFrame(changeFrame), .walk(walk), .dir_left(dir_left),
    .jump_req(jump_req), .anim_state(st1), .frame_idx(idx1), .sprite_sel(sel1),
    .facing_left(face1), .jump_done(done1)
  );

  int errors = 0;
  int checks = 0;

  // Clip-level model: one slot per instance.
  int m_len[2][3] = '{'{2, 4, 3}, '{1, 4, 1}};
  int m_st[2], m_idx[2], m_face[2], m_done[2], m_chg[2];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit step;
    if (Reset) begin
      m_st[k] = 0; m_idx[k] = 0; m_face[k] = 0; m_done[k] = 0;
      m_chg[k] = int'(changeFrame);
      return;
    end
    step = (int'(changeFrame) != m_chg[k]);
    m_chg[k] = int'(changeFrame);
    m_done[k] = 0;
    if (walk && m_st[k] != 2) m_face[k] = int'(dir_left);
    if (m_st[k] == 2) begin
      if (step) begin
        if (m_idx[k] + 1 == m_len[k][2]) begin
          m_st[k] = walk ? 1 : 0;
          m_idx[k] = 0;
          m_done[k] = 1;
        end else begin
          m_idx[k]++;
        end
      end
    end else if (jump_req) begin
      m_st[k] = 2; m_idx[k] = 0;
    end else if (m_st[k] == 0 && walk) begin
      m_st[k] = 1; m_idx[k] = 0;
    end else if (m_st[k] == 1 && !walk) begin
      m_st[k] = 0; m_idx[k] = 0;
    end else if (step) begin
      m_idx[k] = (m_idx[k] + 1) % m_len[k][m_st[k]];
    end
  endtask

  task automatic compare_models();
    chk("d0_state", int'(st0), m_st[0]);
    chk("d0_idx", int'(idx0), m_idx[0]);
    chk("d0_sel", int'(sel0), m_st[0] * 8 + m_idx[0]);
    chk("d0_face", int'(face0), m_face[0]);
    chk("d0_done", int'(done0), m_done[0]);
    chk("d1_state", int'(st1), m_st[1]);
    chk("d1_idx", int'(idx1), m_idx[1]);
    chk("d1_sel", int'(sel1), m_st[1] * 8 + m_idx[1]);
    chk("d1_face", int'(face1), m_face[1]);
    chk("d1_done", int'(done1), m_done[1]);
  endtask

  // Inputs are set just after a rising edge; the next edge consumes them.
  task automatic cycle(input bit rst, input bit cf, input bit w, input bit dl, input bit jr);
    Reset = rst; changeFrame = cf; walk = w; dir_left = dl; jump_req = jr;
    @(posedge Clk);
    model_step(0);
    model_step(1);
    #1;
    compare_models();
  endtask

  typedef struct {
    bit rst, cf, w, dl, jr;
    int n;
    int es, ei, ef, ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit cf, input bit w, input bit dl, input bit jr,
                     input int n, input int es, input int ei, input int ef, input int ed);
    vec_t v;
    v.rst = rst; v.cf = cf; v.w = w; v.dl = dl; v.jr = jr; v.n = n;
    v.es = es; v.ei = ei; v.ef = ef; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    bit cf, w, dl, jr, rst;

    //  rst cf w dl jr  n   state idx face done   (expected for the 2/4/3 instance)
    add(1, 1, 0, 0, 0,  3,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 50,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 19,  0, 1, 0, 0);
    add(0, 1, 0, 0, 0,  1,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1,  0, 1, 0, 0);
    add(0, 0, 1, 1, 0,  1,  1, 0, 1, 0);
    add(0, 1, 1, 1, 0,  1,  1, 1, 1, 0);
    add(0, 0, 1, 1, 0,  1,  1, 2, 1, 0);
    add(0, 1, 1, 1, 0,  1,  1, 3, 1, 0);
    add(0, 0, 1, 1, 0,  1,  1, 0, 1, 0);
    add(0, 1, 1, 1, 0,  1,  1, 1, 1, 0);
    add(0, 1, 0, 0, 0,  1,  0, 0, 1, 0);
    add(0, 1, 1, 0, 0,  1,  1, 0, 0, 0);
    add(0, 0, 1, 0, 1,  1,  2, 0, 0, 0);
    add(0, 0, 1, 1, 0,  5,  2, 0, 0, 0);
    add(0, 1, 1, 1, 0,  1,  2, 1, 0, 0);
    add(0, 1, 1, 1, 1,  1,  2, 1, 0, 0);
    add(0, 0, 1, 0, 0,  1,  2, 2, 0, 0);
    add(0, 1, 1, 1, 0,  1,  1, 0, 0, 1);
    add(0, 1, 1, 1, 0,  1,  1, 0, 1, 0);
    add(0, 1, 0, 0, 1,  1,  2, 0, 1, 0);
    add(0, 0, 0, 0, 0,  1,  2, 1, 1, 0);
    add(1, 1, 0, 0, 0,  1,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  3,  0, 0, 0, 0);
    add(0, 1, 0, 0, 1,  1,  2, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1,  2, 1, 0, 0);
    add(0, 1, 0, 0, 1,  1,  2, 2, 0, 0);
    add(0, 0, 0, 0, 1,  1,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  1,  2, 0, 0, 0);

    Reset = 1'b1; changeFrame = 1'b1; walk = 1'b0; dir_left = 1'b0; jump_req = 1'b0;
    #1;

    foreach (tbl[r]) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        cycle(tbl[r].rst, tbl[r].cf, tbl[r].w, tbl[r].dl, tbl[r].jr);
      end
      chk($sformatf("row%0d_state", r), int'(st0), tbl[r].es);
      chk($sformatf("row%0d_idx", r), int'(idx0), tbl[r].ei);
      chk($sformatf("row%0d_face", r), int'(face0), tbl[r].ef);
      chk($sformatf("row%0d_done", r), int'(done0), tbl[r].ed);
    end

    // Short-clip instance: a single toggle completes its jump.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("len1_enter_jump", int'(st1), 2);
    cycle(0, 1, 0, 0, 0);
    chk("len1_exit_state", int'(st1), 0);
    chk("len1_done", int'(done1), 1);
    cycle(0, 0, 0, 0, 0);
    chk("len1_idle_idx", int'(idx1), 0);

    cf = 1'b0; w = 1'b0; dl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) cf = ~cf;
      if ($urandom_range(0, 15) == 0) w = ~w;
      if ($urandom_range(0, 7) == 0) dl = ~dl;
      jr = ($urandom_range(0, 11) == 0);
      cycle(rst, cf, w, dl, jr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
